// File: rtl/unit_spawn_scheduler.sv
// Spawn scheduler for a pool of Unit slots: latches a spawn request, round-robin picks a dead slot, grants it, then cools down.
// Optional SPAWN_ENERGY_EN adds an energy budget that gates grants and refills on each moveSCEN tick.
module unit_spawn_scheduler #(
    parameter int NUM_UNITS = 8,
    parameter int MOVE_DIV  = 1000,
    parameter int COOLDOWN  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqLeft,
    input  logic                 reqRight,
    input  logic                 reqDown,
    input  logic [NUM_UNITS-1:0] unitDead,
    output logic [NUM_UNITS-1:0] canSpawn,
    output logic                 leftSCEN,
    output logic                 rightSCEN,
    output logic                 downSCEN,
    output logic                 moveSCEN,
    output logic                 spawnFail,
    output logic                 busy,
    output logic [7:0]           energy
);

    localparam int IDXW  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int MOVEW = $clog2(MOVE_DIV);
    localparam int COOLW = $clog2(COOLDOWN);

    typedef enum logic [1:0] {QIdle, QSearch, QGrant, QCool} state_t;

    state_t               state_q;
    logic [1:0]           reqType_q;
    logic [IDXW-1:0]      rrPtr_q;
    logic [IDXW-1:0]      grantIdx_q;
    logic [COOLW-1:0]     coolCnt_q;
    logic [NUM_UNITS-1:0] canSpawn_q;
    logic                 leftSCEN_q;
    logic                 rightSCEN_q;
    logic                 downSCEN_q;
    logic                 spawnFail_q;
    logic [MOVEW-1:0]     moveCnt_q;
    logic [MOVEW-1:0]     moveCnt_d;
    logic                 moveWrap;
    logic                 moveSCEN_q;

    logic [2*NUM_UNITS-1:0] rotated;
    logic                   found;
    logic [IDXW-1:0]        foundIdx;
    logic                   energyOk;
    int                     slot;

    // Rotate the dead mask so bit 0 is the round-robin start, then take the lowest set bit.
    always_comb begin
        rotated  = {unitDead, unitDead} >> rrPtr_q;
        found    = 1'b0;
        foundIdx = '0;
        slot     = 0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            slot = int'(rrPtr_q) + i;
            if (slot >= NUM_UNITS) begin
                slot = slot - NUM_UNITS;
            end
            if (!found && rotated[i]) begin
                found    = 1'b1;
                foundIdx = IDXW'(slot);
            end
        end
    end

    always_comb begin
        moveWrap  = (moveCnt_q == MOVEW'(MOVE_DIV - 1));
        moveCnt_d = moveWrap ? '0 : moveCnt_q + MOVEW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            moveCnt_q  <= '0;
            moveSCEN_q <= 1'b0;
        end else begin
            moveCnt_q  <= moveCnt_d;
            moveSCEN_q <= moveWrap;
        end
    end

`ifdef SPAWN_ENERGY_EN
    logic [7:0] energy_q;
    logic [7:0] energy_d;
    logic [7:0] cost;

    always_comb begin
        case (reqType_q)
            2'd1:    cost = 8'd2;
            2'd2:    cost = 8'd4;
            2'd3:    cost = 8'd8;
            default: cost = 8'd0;
        endcase
        energyOk = (energy_q >= cost);
        energy_d = energy_q;
        // A grant always leaves headroom for the refill, so only the plain refill saturates.
        if (state_q == QGrant) begin
            energy_d = energy_q - cost + {7'd0, moveSCEN_q};
        end else if (moveSCEN_q && (energy_q != 8'hFF)) begin
            energy_d = energy_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            energy_q <= 8'd16;
        end else begin
            energy_q <= energy_d;
        end
    end

    assign energy = energy_q;
`else
    assign energyOk = 1'b1;
    assign energy   = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= QIdle;
            reqType_q   <= 2'd0;
            rrPtr_q     <= '0;
            grantIdx_q  <= '0;
            coolCnt_q   <= '0;
            canSpawn_q  <= '0;
            leftSCEN_q  <= 1'b0;
            rightSCEN_q <= 1'b0;
            downSCEN_q  <= 1'b0;
            spawnFail_q <= 1'b0;
        end else begin
            canSpawn_q  <= '0;
            leftSCEN_q  <= 1'b0;
            rightSCEN_q <= 1'b0;
            downSCEN_q  <= 1'b0;
            spawnFail_q <= 1'b0;
            case (state_q)
                QIdle: begin
                    if (reqLeft) begin
                        reqType_q <= 2'd1;
                        state_q   <= QSearch;
                    end else if (reqRight) begin
                        reqType_q <= 2'd2;
                        state_q   <= QSearch;
                    end else if (reqDown) begin
                        reqType_q <= 2'd3;
                        state_q   <= QSearch;
                    end
                end
                QSearch: begin
                    if (found && energyOk) begin
                        grantIdx_q  <= foundIdx;
                        canSpawn_q  <= NUM_UNITS'(1) << foundIdx;
                        leftSCEN_q  <= (reqType_q == 2'd1);
                        rightSCEN_q <= (reqType_q == 2'd2);
                        downSCEN_q  <= (reqType_q == 2'd3);
                        state_q     <= QGrant;
                    end else begin
                        spawnFail_q <= 1'b1;
                        state_q     <= QIdle;
                    end
                end
                QGrant: begin
                    rrPtr_q   <= (grantIdx_q == IDXW'(NUM_UNITS - 1)) ? '0 : grantIdx_q + IDXW'(1);
                    coolCnt_q <= COOLW'(COOLDOWN - 2);
                    state_q   <= QCool;
                end
                QCool: begin
                    if (coolCnt_q == '0) begin
                        state_q <= QIdle;
                    end else begin
                        coolCnt_q <= coolCnt_q - COOLW'(1);
                    end
                end
                default: state_q <= QIdle;
            endcase
        end
    end

    assign canSpawn  = canSpawn_q;
    assign leftSCEN  = leftSCEN_q;
    assign rightSCEN = rightSCEN_q;
    assign downSCEN  = downSCEN_q;
    assign moveSCEN  = moveSCEN_q;
    assign spawnFail = spawnFail_q;
    assign busy      = (state_q != QIdle);

endmodule

// File: tb/tb_unit_spawn_scheduler.sv
// Directed bench for unit_spawn_scheduler; a second instance with MOVE_DIV=4 checks the move tick.
// Energy expectations follow SPAWN_ENERGY_EN when it is defined for the build.
module tb_unit_spawn_scheduler;

    localparam int COOLDOWN = 16;
`ifdef SPAWN_ENERGY_EN
    localparam bit ENERGY_ON = 1'b1;
`else
    localparam bit ENERGY_ON = 1'b0;
`endif
    localparam logic [7:0] ERESET = ENERGY_ON ? 8'd16 : 8'd0;

    logic       clk = 1'b0;
    logic       reset;
    logic       reqLeft, reqRight, reqDown;
    logic [7:0] unitDead;
    logic [7:0] canSpawn;
    logic       leftSCEN, rightSCEN, downSCEN, moveSCEN, spawnFail, busy;
    logic [7:0] energy;
    logic [7:0] canSpawn2;
    logic       left2, right2, down2, move2, fail2, busy2;
    logic [7:0] energy2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unit_spawn_scheduler #(.NUM_UNITS(8), .MOVE_DIV(1000), .COOLDOWN(COOLDOWN)) dut (
        .clk(clk), .reset(reset), .reqLeft(reqLeft), .reqRight(reqRight), .reqDown(reqDown),
        .unitDead(unitDead), .canSpawn(canSpawn), .leftSCEN(leftSCEN), .rightSCEN(rightSCEN),
        .downSCEN(downSCEN), .moveSCEN(moveSCEN), .spawnFail(spawnFail), .busy(busy), .energy(energy)
    );

    unit_spawn_scheduler #(.NUM_UNITS(8), .MOVE_DIV(4), .COOLDOWN(COOLDOWN)) dutMove (
        .clk(clk), .reset(reset), .reqLeft(reqLeft), .reqRight(reqRight), .reqDown(reqDown),
        .unitDead(unitDead), .canSpawn(canSpawn2), .leftSCEN(left2), .rightSCEN(right2),
        .downSCEN(down2), .moveSCEN(move2), .spawnFail(fail2), .busy(busy2), .energy(energy2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic l, input logic r, input logic d, input logic [7:0] dead);
        unitDead = dead;
        reqLeft  = l;
        reqRight = r;
        reqDown  = d;
        @(negedge clk);
        reqLeft  = 1'b0;
        reqRight = 1'b0;
        reqDown  = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        reqLeft  = 1'b0;
        reqRight = 1'b0;
        reqDown  = 1'b0;
        unitDead = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("rst_canSpawn", {24'd0, canSpawn}, 32'h0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_spawnFail", {31'd0, spawnFail}, 32'd0);
        checkOutput("rst_scen", {29'd0, leftSCEN, rightSCEN, downSCEN}, 32'd0);
        checkOutput("rst_energy", {24'd0, energy}, {24'd0, ERESET});
        checkOutput("move_c0", {31'd0, move2}, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("move_c%0d", k), {31'd0, move2}, {31'd0, (k % 4) == 0});
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);
        checkOutput("left_c1_busy", {31'd0, busy}, 32'd1);
        checkOutput("left_c1_canSpawn", {24'd0, canSpawn}, 32'h0);
        @(negedge clk);
        checkOutput("left_c2_canSpawn", {24'd0, canSpawn}, 32'h01);
        checkOutput("left_c2_scen", {29'd0, leftSCEN, rightSCEN, downSCEN}, 32'b100);
        @(negedge clk);
        checkOutput("left_c3_canSpawn", {24'd0, canSpawn}, 32'h0);
        checkOutput("left_c3_leftSCEN", {31'd0, leftSCEN}, 32'd0);
        repeat (COOLDOWN - 2) @(negedge clk);
        checkOutput("left_cool_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("left_done_busy", {31'd0, busy}, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFE);
        @(negedge clk);
        checkOutput("down_canSpawn", {24'd0, canSpawn}, 32'h02);
        checkOutput("down_scen", {29'd0, leftSCEN, rightSCEN, downSCEN}, 32'b001);
        waitIdle("down_idle");

        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("nofree_spawnFail", {31'd0, spawnFail}, 32'd1);
        checkOutput("nofree_canSpawn", {24'd0, canSpawn}, 32'h0);
        checkOutput("nofree_rightSCEN", {31'd0, rightSCEN}, 32'd0);
        @(negedge clk);
        checkOutput("nofree_fail_drop", {31'd0, spawnFail}, 32'd0);
        checkOutput("nofree_busy", {31'd0, busy}, 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'h40);
        @(negedge clk);
        checkOutput("prio_canSpawn", {24'd0, canSpawn}, 32'h40);
        checkOutput("prio_scen", {29'd0, leftSCEN, rightSCEN, downSCEN}, 32'b100);
        waitIdle("prio_idle");
        checkOutput("prio_energy", {24'd0, energy}, ENERGY_ON ? 32'd4 : 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h81);
        @(negedge clk);
        checkOutput("rr7_canSpawn", {24'd0, canSpawn}, 32'h80);
        waitIdle("rr7_idle");

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h81);
        @(negedge clk);
        checkOutput("rrwrap_canSpawn", {24'd0, canSpawn}, 32'h01);
        waitIdle("rrwrap_idle");
        checkOutput("rrwrap_energy", {24'd0, energy}, 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);
        @(negedge clk);
        checkOutput("empty_canSpawn", {24'd0, canSpawn}, ENERGY_ON ? 32'h0 : 32'h02);
        checkOutput("empty_spawnFail", {31'd0, spawnFail}, ENERGY_ON ? 32'd1 : 32'd0);
        waitIdle("empty_idle");

        applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_canSpawn", {24'd0, canSpawn}, 32'h0);
        checkOutput("abort_rightSCEN", {31'd0, rightSCEN}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_energy", {24'd0, energy}, {24'd0, ERESET});

        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        checkOutput("e1_canSpawn", {24'd0, canSpawn}, 32'h01);
        checkOutput("e1_downSCEN", {31'd0, downSCEN}, 32'd1);
        waitIdle("e1_idle");
        checkOutput("e1_energy", {24'd0, energy}, ENERGY_ON ? 32'd8 : 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        checkOutput("e2_canSpawn", {24'd0, canSpawn}, 32'h02);
        waitIdle("e2_idle");
        checkOutput("e2_energy", {24'd0, energy}, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        checkOutput("e3_canSpawn", {24'd0, canSpawn}, ENERGY_ON ? 32'h0 : 32'h04);
        checkOutput("e3_spawnFail", {31'd0, spawnFail}, ENERGY_ON ? 32'd1 : 32'd0);
        waitIdle("e3_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
